// File: rtl/button_debouncer.sv
// Synchronises and debounces WIDTH raw push-button pins into a clean level plus press/release pulses.
// Latency DEBOUNCE_CYCLES+2 edges from a settled pin change to the registered outputs; no backpressure.
module button_debouncer #(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] level,
    output logic [WIDTH-1:0] press,
    // "release" is a reserved word in SystemVerilog, hence the suffix
    output logic [WIDTH-1:0] release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;

    // Polarity is folded in ahead of the synchroniser so reset (0) means released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= btn ^ {WIDTH{ACTIVE_LOW}};
            sync2 <= sync1;
        end
    end

    for (genvar ch = 0; ch < WIDTH; ch++) begin : g_ch
        state_t        state;
        state_t        state_n;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_n;
        logic          s;
        logic          level_q, press_q, release_q;
        logic          level_n, press_n, release_n;

        assign s                 = sync2[ch];
        assign level[ch]         = level_q;
        assign press[ch]         = press_q;
        assign release_pulse[ch] = release_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state     <= RELEASED;
                cnt       <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                state     <= state_n;
                cnt       <= cnt_n;
                level_q   <= level_n;
                press_q   <= press_n;
                release_q <= release_n;
            end
        end

        always_comb begin
            state_n = state;
            cnt_n   = cnt;
            case (state)
                RELEASED: begin
                    if (s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_n = PRESSED;
                        end else begin
                            state_n = PRESS_WAIT;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                PRESS_WAIT: begin
                    if (!s) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                PRESSED: begin
                    if (!s) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            state_n = RELEASED;
                        end else begin
                            state_n = RELEASE_WAIT;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (s) begin
                        state_n = PRESSED;
                        cnt_n   = '0;
                    end else if (cnt == LAST) begin
                        state_n = RELEASED;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end
                default: begin
                    state_n = RELEASED;
                    cnt_n   = '0;
                end
            endcase
        end

        // Pulses fire only on entry to a stable state from the opposite side.
        always_comb begin
            press_n   = (state == RELEASED || state == PRESS_WAIT) && (state_n == PRESSED);
            release_n = (state == PRESSED || state == RELEASE_WAIT) && (state_n == RELEASED);
            level_n   = (state_n == PRESSED) || (state_n == RELEASE_WAIT);
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed self-checking bench for button_debouncer with WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.
module tb_button_debouncer;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn;
    logic [1:0] level;
    logic [1:0] press;
    logic [1:0] release_pulse;

    int checks = 0;
    int errors = 0;

    button_debouncer #(
        .WIDTH(2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .level(level),
        .press(press),
        .release_pulse(release_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] lv, input logic [1:0] pr,
                             input logic [1:0] rl);
        check({tag, ".level"}, level, lv);
        check({tag, ".press"}, press, pr);
        check({tag, ".release"}, release_pulse, rl);
    endtask

    initial begin
        // Power-on reset with both buttons released (pins high)
        rst = 1'b1;
        btn = 2'b11;
        tick(3);
        check_all("por", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(8);
        check_all("idle", 2'b00, 2'b00, 2'b00);

        // Clean press on channel 0: change lands before edge 0, accepted on edge 5
        btn = 2'b10;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            check_all("press_wait", 2'b00, 2'b00, 2'b00);
        end
        tick(1);
        check_all("press_edge5", 2'b01, 2'b01, 2'b00);
        tick(1);
        check_all("press_edge6", 2'b01, 2'b00, 2'b00);
        for (int e = 0; e < 10; e++) begin
            tick(1);
            check("held_no_repeat", press, 2'b00);
        end

        // Clean release on channel 0
        btn = 2'b11;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            check_all("release_wait", 2'b01, 2'b00, 2'b00);
        end
        tick(1);
        check_all("release_edge5", 2'b00, 2'b00, 2'b01);
        tick(1);
        check_all("release_edge6", 2'b00, 2'b00, 2'b00);

        // Bounce: 2-cycle runs never reach 4 stable samples
        for (int c = 0; c < 20; c++) begin
            btn[0] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
            tick(1);
            check_all("bounce", 2'b00, 2'b00, 2'b00);
        end
        btn = 2'b11;
        for (int c = 0; c < 8; c++) begin
            tick(1);
            check_all("bounce_settle", 2'b00, 2'b00, 2'b00);
        end

        // Simultaneous press on both channels
        btn = 2'b00;
        tick(5);
        check_all("both_wait", 2'b00, 2'b00, 2'b00);
        tick(1);
        check_all("both_press", 2'b11, 2'b11, 2'b00);
        tick(1);
        check("both_press_end", press, 2'b00);

        // Release channel 1 only
        btn = 2'b10;
        tick(5);
        check_all("ch1_rel_wait", 2'b11, 2'b00, 2'b00);
        tick(1);
        check_all("ch1_release", 2'b01, 2'b00, 2'b10);
        tick(1);
        check("ch1_release_end", release_pulse, 2'b00);

        // Asynchronous reset mid-cycle with both buttons pressed
        btn = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 2'b00, 2'b00, 2'b00);
        tick(3);
        check_all("rst_held", 2'b00, 2'b00, 2'b00);
        rst = 1'b0;
        tick(5);
        check_all("post_rst_wait", 2'b00, 2'b00, 2'b00);
        tick(1);
        check_all("post_rst_press", 2'b11, 2'b11, 2'b00);
        tick(1);
        check("post_rst_press_end", press, 2'b00);

        // Return to idle, then reset in the middle of a pending press
        btn = 2'b11;
        tick(8);
        check_all("idle2", 2'b00, 2'b00, 2'b00);
        btn = 2'b10;
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check_all("midwait_rst", 2'b00, 2'b00, 2'b00);
        for (int e = 0; e < 2; e++) begin
            tick(1);
            check_all("midwait_rst_held", 2'b00, 2'b00, 2'b00);
        end
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin
            tick(1);
            check_all("midwait_after", 2'b00, 2'b00, 2'b00);
        end
        tick(1);
        check_all("midwait_press", 2'b01, 2'b01, 2'b00);
        tick(1);
        check_all("midwait_press_end", 2'b01, 2'b00, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions raw, asynchronous, bouncing push-button inputs into clean, clock-synchronous signals for the Alchitry Cu experiments. Each channel is synchronised, then filtered by a per-channel stability counter. The block outputs a debounced level, a one-cycle press pulse and a one-cycle release pulse per button. It sits directly upstream of counter/LED logic, which consumes the press pulses as clock enables instead of using button edges as clocks.

## Interface

Parameters:
- WIDTH, 2, number of independent button channels (≥1).
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a change (≥1; 10 ms at 100 MHz).
- ACTIVE_LOW, 1, 1: raw pin reads 0 when pressed; 0: raw pin reads 1 when pressed.

Ports:
- clk  input  1  system clock, the only clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- btn  input  WIDTH  raw button pins, asynchronous to clk, may bounce.
- level  output  WIDTH  debounced state per channel, 1 = pressed.
- press  output  WIDTH  one-cycle pulse per channel on an accepted press.
- release  output  WIDTH  one-cycle pulse per channel on an accepted release.

## Operation

- Polarity: p = btn XOR {WIDTH{ACTIVE_LOW}}, so p = 1 means pressed. Polarity is applied before the synchroniser.
- Synchroniser: two flops per channel, sync1 then sync2 = s.
  - Reset value is 0 (released), so a held button does not pulse on reset release until debounced.
- Per-channel FSM, with states RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Counter cnt has width $clog2(DEBOUNCE_CYCLES+1).
  - RELEASED:
    - s=1 → PRESS_WAIT with cnt=1.
    - If DEBOUNCE_CYCLES=1, go straight to PRESSED with a press pulse.
  - PRESS_WAIT:
    - s=0 → RELEASED, cnt=0, no pulse.
    - s=1 and cnt==DEBOUNCE_CYCLES-1 → PRESSED; assert press and set level=1 on that same edge.
    - Otherwise cnt+1.
  - PRESSED: mirror of RELEASED, using s=0 → RELEASE_WAIT.
  - RELEASE_WAIT:
    - s=1 → PRESSED, no pulse.
    - s=0 for the DEBOUNCE_CYCLES-th consecutive sample → RELEASED; assert release and set level=0.
- Outputs are registered. level is 1 exactly in PRESSED and RELEASE_WAIT.
- press/release are high for exactly one cycle per accepted transition and never simultaneously on one channel.
- Holding a button produces no repeat pulses.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulses in the same cycle.
- The counter never wraps. It is cleared on every return to a stable state and saturates in use at DEBOUNCE_CYCLES-1.

## Timing

- Reset (async assert) clears to 0 immediately:
  - level, press, release.
  - sync flops and cnt.
  - all FSMs return to RELEASED.
- Reset deasserts synchronously to the design's use; the first sample is taken on the first edge after release.
- Latency: raw change settled before edge 0 → s valid after edge 1 → sampled on edges 2..DEBOUNCE_CYCLES+1 → level/press update on edge DEBOUNCE_CYCLES+1. That is DEBOUNCE_CYCLES+2 rising edges total.
- Any glitch shorter than DEBOUNCE_CYCLES samples after synchronisation is rejected with no output activity.
- Reset mid-wait discards the pending transition; no pulse is emitted.
- A press already held at reset release is accepted after DEBOUNCE_CYCLES+2 edges with a single press pulse.

## Test plan

All scenarios use WIDTH=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1.

- Reset: assert rst mid-simulation with btn=2'b00 → level=0, press=0, release=0 immediately and asynchronously. After release, press[1:0] pulses once each exactly 6 edges later.
- Clean press: btn[0] 1→0 held before edge 0 → level[0]=1 and press[0]=1 after edge 5; press[0]=0 after edge 6; no further pulses while held.
- Bounce rejection: btn[0] toggles 0/1 every 2 cycles for 20 cycles, then returns to 1 → level[0], press[0] and release[0] stay 0 throughout.
- Release: from pressed, btn[0] 0→1 clean → release[0] single pulse and level[0]=0 exactly 6 edges after the change; no press pulse.
- Simultaneous/independent: btn=2'b11→2'b00 in one cycle → press=2'b11 in the same cycle. Then release only btn[1] → release=2'b10 and level=2'b01.
- Reset mid-wait: press btn[0], assert rst after 3 edges, release rst with btn[0] still low → no pulse during reset; press[0] pulses once 6 edges after reset deasserts.
